// File: rtl/gif_pixel_sram_writer.sv
// Packs the decoded GIF palette-index stream two pixels per word and writes it to SRAM,
// counting completed frames so the display side knows where to wrap.
module gif_pixel_sram_writer #(
  parameter logic [19:0] BASE_ADDR = 20'h0CA28,
  parameter logic [19:0] ADDR_MAX  = 20'hFFFFF,
  parameter int unsigned WE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] width_i,
  input  logic [15:0] height_i,
  input  logic [7:0]  pix_data_i,
  input  logic        pix_valid_i,
  input  logic        pix_last_i,
  output logic        pix_ready_o,
  output logic [19:0] sram_addr_o,
  output logic [15:0] sram_dq_out_o,
  output logic        sram_dq_oe_o,
  output logic        sram_we_n_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_ub_n_o,
  output logic        sram_lb_n_o,
  output logic        bus_req_o,
  output logic [7:0]  last_frame_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o
);

  // state      | meaning
  // IDLE       | no load since reset
  // COLLECT_HI | waiting for the even pixel (upper byte)
  // COLLECT_LO | waiting for the odd pixel (lower byte)
  // WRITE      | word on the bus, we_n low for WE_CYCLES clocks
  // RECOVER    | we_n released, data held, address advances
  // DONE       | load finished, bus released
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COLLECT_HI = 3'd1;
  localparam logic [2:0] S_COLLECT_LO = 3'd2;
  localparam logic [2:0] S_WRITE      = 3'd3;
  localparam logic [2:0] S_RECOVER    = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] fp_q, fp_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [20:0] addr_q, addr_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  last_frame_q, last_frame_d;
  logic [3:0]  we_cnt_q, we_cnt_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        last_q, last_d;

  logic        collecting;
  logic        accept;
  logic        out_of_range;
  logic [7:0]  frame_inc;
  logic [31:0] fp_prod;

  assign fp_prod      = {16'h0000, width_i} * {16'h0000, height_i};
  assign collecting   = (state_q == S_COLLECT_HI) || (state_q == S_COLLECT_LO);
  assign accept       = collecting && pix_valid_i;
  // Bit 20 is a sticky carry so a wrap past 20'hFFFFF still reads as out of range.
  assign out_of_range = addr_q > {1'b0, ADDR_MAX};
  assign frame_inc    = (frame_cnt_q == 8'hFF) ? 8'hFF : frame_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    fp_d         = fp_q;
    pix_cnt_d    = pix_cnt_q;
    addr_d       = addr_q;
    word_d       = word_q;
    frame_cnt_d  = frame_cnt_q;
    last_frame_d = last_frame_q;
    we_cnt_d     = we_cnt_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    last_d       = last_q;

    if (accept) begin
      if (pix_cnt_q == fp_q - 32'd1) begin
        pix_cnt_d    = 32'd0;
        frame_cnt_d  = frame_inc;
        last_frame_d = frame_inc - 8'd1;
      end else begin
        pix_cnt_d = pix_cnt_q + 32'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          fp_d         = fp_prod;
          addr_d       = {1'b0, BASE_ADDR};
          pix_cnt_d    = 32'd0;
          frame_cnt_d  = 8'd0;
          last_frame_d = 8'd0;
          done_d       = 1'b0;
          ovf_d        = 1'b0;
          last_d       = 1'b0;
          if (fp_prod == 32'd0) begin
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT_HI;
          end
        end
      end
      S_COLLECT_HI: begin
        if (accept) begin
          word_d = {pix_data_i, 8'h00};
          if (pix_last_i) begin
            last_d   = 1'b1;
            we_cnt_d = WE_LOAD;
            state_d  = S_WRITE;
          end else begin
            state_d = S_COLLECT_LO;
          end
        end
      end
      S_COLLECT_LO: begin
        if (accept) begin
          word_d[7:0] = pix_data_i;
          last_d      = pix_last_i;
          we_cnt_d    = WE_LOAD;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (out_of_range) ovf_d = 1'b1;
        if (we_cnt_q == 4'd0) state_d = S_RECOVER;
        else                  we_cnt_d = we_cnt_q - 4'd1;
      end
      S_RECOVER: begin
        addr_d = {addr_q[20] | (&addr_q[19:0]), addr_q[19:0] + 20'd1};
        if (last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      fp_q         <= 32'd0;
      pix_cnt_q    <= 32'd0;
      addr_q       <= 21'd0;
      word_q       <= 16'd0;
      frame_cnt_q  <= 8'd0;
      last_frame_q <= 8'd0;
      we_cnt_q     <= 4'd0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fp_q         <= fp_d;
      pix_cnt_q    <= pix_cnt_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      frame_cnt_q  <= frame_cnt_d;
      last_frame_q <= last_frame_d;
      we_cnt_q     <= we_cnt_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_ub_n_o  = 1'b1;
    sram_lb_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_dq_oe_o = 1'b0;
    if (state_q == S_WRITE || state_q == S_RECOVER) begin
      sram_ce_n_o  = 1'b0;
      sram_ub_n_o  = 1'b0;
      sram_lb_n_o  = 1'b0;
      sram_dq_oe_o = 1'b1;
      sram_we_n_o  = (state_q == S_RECOVER) || out_of_range;
    end
  end

  assign pix_ready_o   = collecting;
  assign sram_addr_o   = addr_q[19:0];
  assign sram_dq_out_o = word_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus_req_o     = busy_o;
  assign last_frame_o  = last_frame_q;
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_gif_pixel_sram_writer.sv
// Scoreboard bench: a load-level model predicts every SRAM word write; a bus monitor pops and compares.
module tb_gif_pixel_sram_writer;
  localparam logic [19:0] BASE = 20'hFFFF8;
  localparam logic [19:0] AMAX = 20'hFFFFF;
  localparam int          WEC  = 3;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i;
  logic [15:0] width_i, height_i;
  logic [7:0]  pix_data_i;
  logic        pix_valid_i, pix_last_i;
  logic        pix_ready_o;
  logic [19:0] sram_addr_o;
  logic [15:0] sram_dq_out_o;
  logic        sram_dq_oe_o, sram_we_n_o, sram_ce_n_o, sram_oe_n_o, sram_ub_n_o, sram_lb_n_o;
  logic        bus_req_o, busy_o, done_o, overflow_o;
  logic [7:0]  last_frame_o;

  gif_pixel_sram_writer #(.BASE_ADDR(BASE), .ADDR_MAX(AMAX), .WE_CYCLES(WEC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .width_i(width_i), .height_i(height_i),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_last_i(pix_last_i),
    .pix_ready_o(pix_ready_o), .sram_addr_o(sram_addr_o), .sram_dq_out_o(sram_dq_out_o),
    .sram_dq_oe_o(sram_dq_oe_o), .sram_we_n_o(sram_we_n_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_ub_n_o(sram_ub_n_o), .sram_lb_n_o(sram_lb_n_o),
    .bus_req_o(bus_req_o), .last_frame_o(last_frame_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];
  logic [7:0]  pix_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Bus monitor: every falling we_n is one word write that must match the head of the queue.
  bit          in_wr = 1'b0;
  int          run = 0;
  logic [35:0] cur;
  always begin
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      in_wr = 1'b0;
    end else begin
      if (sram_dq_oe_o) check("ready_during_write", 32'(pix_ready_o), 32'd0);
      if (!sram_we_n_o) begin
        if (!in_wr) begin
          in_wr = 1'b1;
          run = 1;
          cur = {sram_addr_o, sram_dq_out_o};
          check("write_strobes", {27'd0, sram_ce_n_o, sram_oe_n_o, sram_ub_n_o, sram_lb_n_o, sram_dq_oe_o},
                32'b01001);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required=no write",
                     sram_addr_o, sram_dq_out_o);
          end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            check("write_addr", 32'(sram_addr_o), 32'(e[35:16]));
            check("write_data", 32'(sram_dq_out_o), 32'(e[15:0]));
          end
        end else begin
          run++;
          check("write_hold", {cur[35:16], 12'd0} | 32'(sram_dq_out_o ^ cur[15:0]), {sram_addr_o, 12'd0});
        end
      end else if (in_wr) begin
        in_wr = 1'b0;
        check("we_low_cycles", 32'(run), 32'(WEC));
        check("recover_hold", {cur[35:16], 12'd0} | 32'(sram_dq_out_o ^ cur[15:0]), {sram_addr_o, 12'd0});
      end
    end
  end

  task automatic pulse_start(input int w, input int h);
    @(negedge clk_i);
    start_i  = 1'b1;
    width_i  = 16'(w);
    height_i = 16'(h);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // gaps: 0 = valid always high, 1 = valid every other cycle, 2 = random gaps
  task automatic send_pixel(input logic [7:0] d, input bit last, input int gaps);
    bit sent = 1'b0;
    int cnt = 0;
    while (!sent && cnt < 200) begin
      @(negedge clk_i);
      cnt++;
      if ((gaps == 1 && !pix_valid_i) || (gaps == 2 && $urandom_range(0, 2) == 0) || gaps == 0) begin
        pix_valid_i = 1'b1;
        pix_data_i  = d;
        pix_last_i  = last;
        if (pix_ready_o) sent = 1'b1;
      end else begin
        pix_valid_i = 1'b0;
      end
    end
    if (!sent) begin
      checks++;
      failures++;
      $display("FAIL pixel_accept_timeout actual=not accepted required=accepted");
    end
  endtask

  task automatic run_load(input int w, input int h, input int gaps);
    int          fp, n, frames, exp_lf, cnt;
    bit          exp_ovf;
    logic [20:0] a;
    logic [7:0]  hi, lo;
    fp = w * h;
    n = pix_q.size();
    exp_ovf = (fp == 0);
    if (fp != 0) begin
      for (int k = 0; k < (n + 1) / 2; k++) begin
        a  = {1'b0, BASE} + 21'(k);
        hi = pix_q[2*k];
        lo = (2*k + 1 < n) ? pix_q[2*k+1] : 8'h00;
        if (a <= {1'b0, AMAX}) exp_q.push_back({a[19:0], hi, lo});
        else exp_ovf = 1'b1;
      end
    end
    frames = (fp != 0) ? n / fp : 0;
    if (frames > 255) frames = 255;
    exp_lf = (frames > 0) ? frames - 1 : 0;

    pulse_start(w, h);
    if (fp != 0) begin
      for (int i = 0; i < n; i++) send_pixel(pix_q[i], i == n - 1, gaps);
      @(negedge clk_i);
      pix_valid_i = 1'b0;
      pix_last_i  = 1'b0;
    end
    cnt = 0;
    while (!done_o && cnt < 5000) begin
      @(negedge clk_i);
      cnt++;
    end
    check("done", 32'(done_o), 32'd1);
    check("overflow", 32'(overflow_o), 32'(exp_ovf));
    check("last_frame", 32'(last_frame_o), 32'(exp_lf));
    check("busy_after_done", {30'd0, busy_o, bus_req_o}, 32'd0);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    pix_q.delete();
  endtask

  initial begin
    int w, h, n, cnt;
    rst_i = 1'b1; start_i = 1'b0; width_i = '0; height_i = '0;
    pix_data_i = '0; pix_valid_i = 1'b0; pix_last_i = 1'b0;
    #1;
    check("reset_strobes", {23'd0, sram_we_n_o, sram_ce_n_o, sram_oe_n_o, sram_ub_n_o, sram_lb_n_o,
                            sram_dq_oe_o, pix_ready_o, bus_req_o, busy_o}, 32'b111110000);
    check("reset_bus", {sram_addr_o, 12'd0} | 32'(sram_dq_out_o), 32'd0);
    check("reset_flags", {22'd0, last_frame_o, done_o, overflow_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset during the first word write.
    for (int i = 0; i < 8; i++) pix_q.push_back(8'(8'hA0 + i));
    exp_q.push_back({BASE, 8'hA0, 8'hA1});
    pulse_start(4, 2);
    send_pixel(8'hA0, 1'b0, 0);
    send_pixel(8'hA1, 1'b0, 0);
    @(negedge clk_i);
    pix_valid_i = 1'b0;
    cnt = 0;
    while (sram_we_n_o && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    check("we_low_before_reset", 32'(sram_we_n_o), 32'd0);
    #2 rst_i = 1'b1;
    #1;
    check("reset_mid_write", {28'd0, sram_we_n_o, sram_dq_oe_o, busy_o, pix_ready_o}, 32'b1000);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("after_reset_idle", {29'd0, busy_o, done_o, overflow_o}, 32'd0);
    check("after_reset_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    pix_q.delete();

    // Two 4x2 frames, pixels 0x00..0x0F.
    for (int i = 0; i < 16; i++) pix_q.push_back(8'(i));
    run_load(4, 2, 0);
    // Odd frame size: last word padded with zero.
    pix_q.push_back(8'hAA); pix_q.push_back(8'hBB); pix_q.push_back(8'hCC);
    run_load(3, 1, 1);
    // Runs past the address limit: last two words suppressed.
    for (int i = 0; i < 20; i++) pix_q.push_back(8'($urandom));
    run_load(5, 4, 1);
    // Zero-sized frame.
    run_load(7, 0, 0);
    // Frame counter saturation.
    for (int i = 0; i < 300; i++) pix_q.push_back(8'($urandom));
    run_load(1, 1, 0);
    for (int i = 0; i < 22; i++) pix_q.push_back(8'($urandom));
    run_load(2, 2, 2);

    for (int t = 0; t < 12; t++) begin
      w = $urandom_range(0, 4);
      h = $urandom_range(1, 4);
      n = (w == 0) ? 0 : $urandom_range(1, 24);
      for (int i = 0; i < n; i++) pix_q.push_back(8'($urandom));
      run_load(w, h, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
